// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU.
// Owns PC and IR, time-multiplexes the single memory port, and drives the ALU and register-file controls.
module cpu_ctrl_fsm #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [15:0] rf_rdata1,
    input  logic        alu_zero,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic [11:0] pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic        alu_en,
    output logic [2:0]  alu_op,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        halted,
    output logic        illegal
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] S_FETCH  = 3'd1;
    localparam logic [ST_W-1:0] S_DECODE = 3'd2;
    localparam logic [ST_W-1:0] S_EXEC   = 3'd3;
    localparam logic [ST_W-1:0] S_MEM    = 3'd4;
    localparam logic [ST_W-1:0] S_WB     = 3'd5;
    localparam logic [ST_W-1:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BZ    = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nx;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_ir_nx;
    logic              r_zflag;
    logic              w_zflag_nx;
    logic [DATA_W-1:0] r_load_data;
    logic [DATA_W-1:0] w_load_data_nx;

    logic w_is_alu;
    logic w_is_illegal;
    logic w_is_mem;
    logic w_unused;

    assign w_is_alu     = (opcode != OP_NOP) && !opcode[3];
    assign w_is_illegal = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);
    assign w_is_mem     = (opcode == OP_LOAD) || (opcode == OP_STORE);

    // Load data is parked for the WB cycle; upper src1 bits are not part of the address.
    assign w_unused = ^{r_load_data, rf_rdata1[DATA_W-1:ADDR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_zflag     <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_ir        <= w_ir_nx;
            r_zflag     <= w_zflag_nx;
            r_load_data <= w_load_data_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_ir_nx        = r_ir;
        w_zflag_nx     = r_zflag;
        w_load_data_nx = r_load_data;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_ir_nx    = mem_rdata;
                    w_pc_nx    = r_pc + ADDR_W'(1);
                    w_state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_alu || (opcode == OP_JMP) || (opcode == OP_BZ)) w_state_nx = S_EXEC;
                else if (w_is_mem)                                       w_state_nx = S_MEM;
                else if (opcode == OP_HALT)                              w_state_nx = S_HALT;
                else                                                     w_state_nx = S_FETCH;
            end
            S_EXEC: begin
                w_state_nx = S_FETCH;
                if (w_is_alu) begin
                    w_zflag_nx = alu_zero;
                    w_state_nx = S_WB;
                end else if ((opcode == OP_JMP) || ((opcode == OP_BZ) && r_zflag)) begin
                    w_pc_nx = r_ir[ADDR_W-1:0];
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        w_state_nx = S_FETCH;
                    end else begin
                        w_load_data_nx = mem_rdata;
                        w_state_nx     = S_WB;
                    end
                end
            end
            S_WB:    w_state_nx = S_FETCH;
            S_HALT:  w_state_nx = S_HALT;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Moore output decode; only the MEM address passes src1 straight through.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        alu_en   = 1'b0;
        alu_op   = '0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
            end
            S_DECODE: illegal = w_is_illegal;
            S_EXEC: begin
                if (w_is_alu) begin
                    alu_en = 1'b1;
                    alu_op = opcode[2:0];
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_STORE);
                mem_addr = rf_rdata1[ADDR_W-1:0];
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = (opcode == OP_LOAD);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign pc = r_pc;
    assign ir = r_ir;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: an instruction-level model expands each instruction into its expected
// per-cycle outputs; directed programs cover the test plan, then a randomized program stream runs.
module tb_cpu_ctrl_fsm;

    localparam logic [11:0] RESET_PC = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcode;
    logic [15:0] rf_rdata1 = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir;
    logic [11:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic        alu_en;
    logic [2:0]  alu_op;
    logic        rf_we;
    logic        wb_sel;
    logic        halted;
    logic        illegal;

    cpu_ctrl_fsm #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .rf_rdata1(rf_rdata1), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .ir(ir), .pc(pc), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .alu_en(alu_en), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .illegal(illegal)
    );

    // The decoder is a pure slice of IR.
    assign opcode = ir[15:12];

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [11:0] addr;
        logic        alu_en;
        logic [2:0]  alu_op;
        logic        rf_we;
        logic        wb_sel;
        logic        halted;
        logic        illegal;
        logic [11:0] pc;
        logic [15:0] ir;
    } exp_t;

    logic [15:0] mem [4096];
    logic [11:0] m_pc;
    logic [15:0] m_ir;
    logic        m_z;
    logic        m_halted;
    exp_t        exp_q;
    logic        chk = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Single compare point, away from the active edge.
    always @(negedge clk) begin
        if (chk) begin
            check("mem_req",  16'(mem_req),  16'(exp_q.req));
            check("mem_we",   16'(mem_we),   16'(exp_q.we));
            check("mem_addr", 16'(mem_addr), 16'(exp_q.addr));
            check("alu_en",   16'(alu_en),   16'(exp_q.alu_en));
            check("alu_op",   16'(alu_op),   16'(exp_q.alu_op));
            check("rf_we",    16'(rf_we),    16'(exp_q.rf_we));
            check("wb_sel",   16'(wb_sel),   16'(exp_q.wb_sel));
            check("halted",   16'(halted),   16'(exp_q.halted));
            check("illegal",  16'(illegal),  16'(exp_q.illegal));
            check("pc",       16'(pc),       16'(exp_q.pc));
            check("ir",       ir,            exp_q.ir);
        end
    end

    function automatic exp_t base_exp();
        exp_t e;
        e    = '0;
        e.pc = m_pc;
        e.ir = m_ir;
        return e;
    endfunction

    task automatic step(input exp_t e, input logic rdy, input logic [15:0] rdata,
                        input logic [15:0] rf1, input logic az, input logic st);
        mem_ready = rdy;
        mem_rdata = rdata;
        rf_rdata1 = rf1;
        alu_zero  = az;
        start     = st;
        exp_q     = e;
        chk       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step_r(input exp_t e);
        step(e, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic idle_step(input logic st);
        step(base_exp(), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), st);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        m_pc     = RESET_PC;
        m_ir     = '0;
        m_z      = 1'b0;
        m_halted = 1'b0;
        exp_q    = base_exp();
        chk      = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one instruction from m_pc: fw fetch waits, mw data waits, rf1 = src1 value in MEM,
    // az_sel 0/1 forces alu_zero in EXEC, 2 randomizes it. cyc returns the cycles spent.
    task automatic run_instr(input int fw, input int mw, input logic [15:0] rf1,
                             input int az_sel, output int cyc);
        logic [15:0] ins;
        logic [3:0]  op;
        logic        az;
        exp_t        e;
        cyc = 0;
        ins = mem[m_pc];
        for (int w = 0; w <= fw; w++) begin
            e = base_exp(); e.req = 1'b1; e.addr = m_pc;
            step(e, w == fw, (w == fw) ? ins : 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            cyc++;
        end
        m_ir = ins;
        m_pc = m_pc + 12'd1;
        op   = ins[15:12];
        e = base_exp(); e.illegal = (op >= 4'hC) && (op <= 4'hE);
        step_r(e);
        cyc++;
        if ((op >= 4'h1) && (op <= 4'h7)) begin
            az = (az_sel == 2) ? 1'($urandom) : 1'(az_sel);
            e = base_exp(); e.alu_en = 1'b1; e.alu_op = op[2:0];
            step(e, 1'($urandom), 16'($urandom), 16'($urandom), az, 1'($urandom));
            m_z = az;
            e = base_exp(); e.rf_we = 1'b1;
            step_r(e);
            cyc += 2;
        end else if ((op == 4'hA) || (op == 4'hB)) begin
            step_r(base_exp());
            cyc++;
            if ((op == 4'hA) || m_z) m_pc = ins[11:0];
        end else if ((op == 4'h8) || (op == 4'h9)) begin
            for (int w = 0; w <= mw; w++) begin
                e = base_exp(); e.req = 1'b1; e.we = (op == 4'h9); e.addr = rf1[11:0];
                step(e, w == mw, 16'($urandom), rf1, 1'($urandom), 1'($urandom));
                cyc++;
            end
            if (op == 4'h8) begin
                e = base_exp(); e.rf_we = 1'b1; e.wb_sel = 1'b1;
                step_r(e);
                cyc++;
            end
        end else if (op == 4'hF) begin
            m_halted = 1'b1;
        end
    endtask

    task automatic halted_steps(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = base_exp(); e.halted = 1'b1;
            step(e, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        int   cyc;
        exp_t e;
        logic [3:0] op;

        // Directed program following the test plan.
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h1123;
        mem[12'h001] = 16'hB010;
        mem[12'h010] = 16'h8504;
        mem[12'h011] = 16'h9560;
        mem[12'h012] = 16'hA123;
        mem[12'h123] = 16'h2000;
        mem[12'h124] = 16'hB050;
        mem[12'h125] = 16'hD000;
        mem[12'h126] = 16'h0000;
        mem[12'h127] = 16'hF000;
        mem[12'h040] = 16'hBEEF;

        do_reset();
        check("reset_pc", 16'(pc), 16'h0000);
        check("reset_ir", ir, 16'h0000);
        idle_step(1'b0);
        idle_step(1'b0);
        idle_step(1'b1);
        run_instr(0, 0, 16'h0000, 1, cyc);
        check("lat_add", 16'(cyc), 16'd4);
        check("pc_after_add", 16'(pc), 16'h0001);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("lat_bz_taken", 16'(cyc), 16'd3);
        check("pc_bz_taken", 16'(pc), 16'h0010);
        run_instr(0, 3, 16'h0040, 2, cyc);
        check("lat_load_3wait", 16'(cyc), 16'd7);
        run_instr(1, 0, 16'($urandom), 2, cyc);
        check("lat_store_fwait", 16'(cyc), 16'd4);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("lat_jmp", 16'(cyc), 16'd3);
        check("fetch_addr_after_jmp", 16'(mem_addr), 16'h0123);
        run_instr(0, 0, 16'h0000, 0, cyc);
        check("lat_alu", 16'(cyc), 16'd4);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("pc_bz_not_taken", 16'(pc), 16'h0125);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("lat_illegal", 16'(cyc), 16'd2);
        check("pc_after_illegal", 16'(pc), 16'h0126);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("lat_nop", 16'(cyc), 16'd2);
        run_instr(0, 0, 16'h0000, 2, cyc);
        halted_steps(10);
        check("halted_sticky", 16'(halted), 16'h0001);
        check("pc_in_halt", 16'(pc), 16'h0128);

        // PC wrap at the top of the address space.
        mem[12'h000] = 16'hAFFF;
        mem[12'hFFF] = 16'h7000;
        do_reset();
        idle_step(1'b1);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("pc_at_fff", 16'(pc), 16'h0FFF);
        run_instr(0, 0, 16'h0000, 2, cyc);
        check("pc_wrapped", 16'(pc), 16'h0000);

        // Asynchronous reset in the middle of a data-memory wait.
        mem[12'h000] = 16'h8504;
        do_reset();
        idle_step(1'b1);
        e = base_exp(); e.req = 1'b1; e.addr = m_pc;
        step(e, 1'b1, mem[12'h000], 16'($urandom), 1'b0, 1'b0);
        m_ir = mem[12'h000];
        m_pc = m_pc + 12'd1;
        step_r(base_exp());
        e = base_exp(); e.req = 1'b1; e.addr = 12'h040;
        step(e, 1'b0, 16'($urandom), 16'h0040, 1'b0, 1'b0);
        step(e, 1'b0, 16'($urandom), 16'h0040, 1'b0, 1'b0);
        check("mem_req_before_rst", 16'(mem_req), 16'h0001);
        chk   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", 16'(mem_req), 16'h0000);
        check("rst_mem_addr", 16'(mem_addr), 16'h0000);
        check("rst_pc", 16'(pc), 16'(RESET_PC));
        check("rst_ir", ir, 16'h0000);
        m_pc     = RESET_PC;
        m_ir     = '0;
        m_z      = 1'b0;
        m_halted = 1'b0;
        exp_q    = base_exp();
        chk      = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_step(1'b0);
        idle_step(1'b1);
        run_instr(0, 0, 16'h0040, 2, cyc);
        check("lat_load_after_rst", 16'(cyc), 16'd4);

        // Randomized program stream; HALT is rare so long runs form between resets.
        for (int i = 0; i < 4096; i++) begin
            op = 4'($urandom_range(0, 15));
            if ((op == 4'hF) && ($urandom_range(0, 39) != 0)) op = 4'h0;
            mem[i] = {op, 12'($urandom)};
        end
        do_reset();
        idle_step(1'b1);
        for (int n = 0; n < 1200; n++) begin
            if (m_halted) begin
                halted_steps(3);
                do_reset();
                idle_step(1'b0);
                idle_step(1'b1);
            end
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      16'($urandom), 2, cyc);
        end

        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the 16-bit CPU. It owns the PC and instruction register and feeds IR to the combinational instruction decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and arbitrates the single shared memory port between instruction fetch and load/store. It also drives the ALU, register-file write and writeback-select controls.

## Interface
- RESET_PC, 12'h000, PC value loaded on reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching at current PC.
- opcode  in  4  from decoder: ir[15:12].
- rf_rdata1  in  16  register-file read port 1 (src1); low 12 bits form the load/store address.
- alu_zero  in  1  ALU result-zero, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_rdata  in  16  memory read data, valid with mem_ready.
- ir  out  16  instruction register → decoder.
- pc  out  12  program counter.
- mem_req, mem_we  out  1 each  memory request; write enable.
- mem_addr  out  12  memory address.
- alu_en  out  1  ALU evaluate strobe.
- alu_op  out  3  ALU function = opcode[2:0].
- rf_we  out  1  register-file write enable (dest = ir[3:0]).
- wb_sel  out  1  0 = ALU result, 1 = memory load data.
- halted, illegal  out  1 each  HALT reached; 1-cycle illegal-opcode pulse.

## Operation
- Opcode map:
  - 0x0 NOP.
  - 0x1–0x7 ALU R-type: rd = src1 op src2.
  - 0x8 LOAD: rd = mem[rf[src1]].
  - 0x9 STORE: mem[rf[src1]] = rf[src2]; the datapath drives write data from read port 2.
  - 0xA JMP: pc = ir[11:0].
  - 0xB BZ: pc = ir[11:0] if zflag.
  - 0xF HALT.
  - 0xC–0xE illegal: executed as NOP, pulse illegal in DECODE.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: all strobes low. start=1 → FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Held until mem_ready. On mem_ready: ir←mem_rdata, pc←pc+1 (12-bit wrap 0xFFF→0x000), → DECODE.
- DECODE (1 cycle), next state by opcode:
  - ALU, JMP, BZ → EXEC.
  - LOAD, STORE → MEM.
  - HALT → HALT.
  - NOP/illegal → FETCH.
- EXEC (1 cycle):
  - ALU: alu_en=1, alu_op=opcode[2:0], zflag←alu_zero, → WB.
  - JMP: pc←ir[11:0], → FETCH.
  - BZ: if zflag, pc←ir[11:0]; → FETCH.
- MEM: mem_req=1, mem_addr=rf_rdata1[11:0], mem_we=(opcode==0x9). Held until mem_ready.
  - LOAD → WB; the load data is captured into a holding register.
  - STORE → FETCH.
- WB (1 cycle): rf_we=1. wb_sel=1 for LOAD, 0 for ALU. → FETCH.
- HALT: halted=1, terminal. Only rst_n exits; start is ignored.
- zflag is internal. It updates only on ALU EXEC and resets to 0.
- Arbitration: the memory port is time-multiplexed by state only (FETCH vs MEM), so fetch and data accesses are never simultaneous.

## Timing
- Reset (asynchronous assert, synchronous to clk on release) forces:
  - state=IDLE, pc=RESET_PC, ir=16'h0000, zflag=0.
  - Every output 0, including mem_req, rf_we, halted and illegal.
  - Reset mid-request drops mem_req immediately. No partial write is committed by this block.
- All outputs are registered-state Moore decodes, except mem_addr in MEM, which follows rf_rdata1 combinationally.
- mem_req, mem_we and mem_addr stay stable while waiting for mem_ready.
- The state machine advances on the same edge mem_ready is sampled high.
- Latency in clk cycles, zero-wait memory, FETCH included:
  - NOP/illegal 2.
  - JMP/BZ 3.
  - STORE 3.
  - ALU 4.
  - LOAD 4.
  - Each memory wait cycle adds 1.
- The pc seen during DECODE/EXEC is already incremented. A taken branch overrides the increment.
- start asserted outside IDLE has no effect.

## Test plan
- Reset then start, memory at 0x000 = 16'h1123 (ADD r3=r1+r2), zero-wait:
  - FETCH→DECODE→EXEC→WB.
  - alu_en high 1 cycle with alu_op=3'b001.
  - rf_we high 1 cycle with wb_sel=0; pc=0x001.
- LOAD 16'h8504 with rf_rdata1=16'h0040 and mem_ready delayed 3 cycles:
  - mem_addr=0x040 and mem_we=0 held 4 cycles.
  - WB then has rf_we=1, wb_sel=1.
- STORE 16'h9560:
  - One MEM cycle with mem_we=1, mem_addr=rf_rdata1[11:0].
  - rf_we never asserts.
- Control flow:
  - JMP 16'hA123 → next fetch mem_addr=0x123.
  - BZ after an ALU op with alu_zero=1 is taken; with alu_zero=0, pc continues sequentially.
- Opcode 0xD → illegal pulses 1 cycle in DECODE, then FETCH at pc+1. HALT 16'hF000 → halted=1 and start ignored for 10 cycles.
- Edge cases:
  - With pc=0xFFF, the fetch wraps pc to 0x000.
  - rst_n low during a MEM wait → all outputs 0 the same cycle, pc=RESET_PC, IDLE.
